// File: rtl/dmem_responder_if.sv
// ============================================================================
// Module      : dmem_responder_if
// Description : MEM-stage <-> data-memory request/response bundle.
//               master = pipeline MEM stage, slave = memory responder.
// Ports       : mem_read/mem_write/addr/wdata/funct3 (request, master->slave)
//               rdata/rvalid/mem_stall/mem_err     (response, slave->master)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic [31:0] rdata;
    logic        rvalid;
    logic        mem_stall;
    logic        mem_err;

    modport master (
        output mem_read, mem_write, addr, wdata, funct3,
        input  rdata, rvalid, mem_stall, mem_err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata, funct3,
        output rdata, rvalid, mem_stall, mem_err
    );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder for the pipeline MEM stage. Accepts a
//               load/store, waits WAIT_STATES cycles, then responds for one
//               cycle. Byte/half/word accesses, little-endian word array.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous active-high reset
//               bus   - dmem_responder_if.slave (request in, response out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
    parameter int WAIT_STATES = 2,
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_wait = 2'd1;
    localparam logic [1:0] c_resp = 2'd2;

    // Counter preload: WAIT is entered with WAIT_STATES-1 and leaves at zero.
    localparam logic [3:0] c_cnt_load = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic [3:0]    r_cnt;

    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [2:0]    r_funct3;
    logic          r_write;
    logic          r_err;

    logic [31:0]   r_rdata;
    logic          r_rvalid;
    logic          r_mem_err;

    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_req;
    logic          w_accept;
    logic          w_f3_ok;
    logic          w_misalign;
    logic          w_range_err;
    logic          w_req_err;

    logic [AW+1:0] w_addr;
    logic [2:0]    w_funct3;
    logic          w_write;
    logic          w_err;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;

    logic [3:0]    w_be;
    logic [31:0]   w_wlanes;

    assign w_req    = bus.mem_read | bus.mem_write;
    assign w_accept = (r_state == c_idle) & w_req;

    // Request legality, evaluated on the live request in IDLE.
    always_comb begin
        w_f3_ok    = 1'b0;
        w_misalign = 1'b0;
        case (bus.funct3)
            3'b000, 3'b100: w_f3_ok = 1'b1;
            3'b001, 3'b101: begin
                w_f3_ok    = 1'b1;
                w_misalign = bus.addr[0];
            end
            3'b010: begin
                w_f3_ok    = 1'b1;
                w_misalign = |bus.addr[1:0];
            end
            default: ;
        endcase
    end

    assign w_range_err = (bus.addr[31:2] >= 30'(DEPTH_WORDS));
    assign w_req_err   = ~w_f3_ok | w_misalign | w_range_err
                       | (bus.mem_read & bus.mem_write);

    // With zero wait states RESP follows IDLE directly, so the load result is
    // formed from the live request; otherwise from the latched copy.
    assign w_addr   = (r_state == c_idle) ? bus.addr[AW+1:0] : r_addr;
    assign w_funct3 = (r_state == c_idle) ? bus.funct3       : r_funct3;
    assign w_write  = (r_state == c_idle) ? bus.mem_write    : r_write;
    assign w_err    = (r_state == c_idle) ? w_req_err        : r_err;

    assign w_word = r_mem[w_addr[AW+1:2]];
    assign w_byte = w_word[{w_addr[1:0], 3'b000} +: 8];
    assign w_half = w_word[{w_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_load = 32'd0;
        case (w_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            3'b010:  w_load = w_word;
            default: w_load = 32'd0;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle: if (w_req) w_next = (WAIT_STATES > 0) ? c_wait : c_resp;
            c_wait: if (r_cnt == 4'd0) w_next = c_resp;
            c_resp: w_next = c_idle;
            default: w_next = c_idle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.mem_stall = ((r_state == c_idle) & w_req) | (r_state == c_wait);
    end

    assign bus.rdata   = r_rdata;
    assign bus.rvalid  = r_rvalid;
    assign bus.mem_err = r_mem_err;

    // Request latch, wait counter and registered response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= 4'd0;
            r_addr    <= '0;
            r_wdata   <= 32'd0;
            r_funct3  <= 3'd0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= 32'd0;
            r_rvalid  <= 1'b0;
            r_mem_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr   <= bus.addr[AW+1:0];
                r_wdata  <= bus.wdata;
                r_funct3 <= bus.funct3;
                r_write  <= bus.mem_write;
                r_err    <= w_req_err;
                r_cnt    <= c_cnt_load;
            end else if ((r_state == c_wait) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            r_rvalid  <= (w_next == c_resp);
            r_mem_err <= (w_next == c_resp) & w_err;
            // Stores and faulted accesses respond with zero data.
            if (w_next == c_resp) begin
                r_rdata <= (w_err | w_write) ? 32'd0 : w_load;
            end
        end
    end

    // Byte-lane enables and lane-replicated store data.
    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = r_wdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_be     = 4'b0001 << r_addr[1:0];
                w_wlanes = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be     = 4'b1111;
                w_wlanes = r_wdata;
            end
        endcase
    end

    // Store commits on the edge that ends RESP; reset forces IDLE first, so
    // an aborted store never reaches the array.
    always_ff @(posedge clk) begin
        if ((r_state == c_resp) && r_write && !r_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[r_addr[AW+1:2]][8*b +: 8] <= w_wlanes[8*b +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder. u_dut0 runs
//               with WAIT_STATES=2, u_dut1 with WAIT_STATES=0; sel steers the
//               shared request onto one of them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [2:0]  funct3 = 3'd0;

    int n_chk = 0;
    int n_bad = 0;

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();

    assign bus0.mem_read  = mem_read  & ~sel;
    assign bus0.mem_write = mem_write & ~sel;
    assign bus0.addr      = addr;
    assign bus0.wdata     = wdata;
    assign bus0.funct3    = funct3;
    assign bus1.mem_read  = mem_read  & sel;
    assign bus1.mem_write = mem_write & sel;
    assign bus1.addr      = addr;
    assign bus1.wdata     = wdata;
    assign bus1.funct3    = funct3;

    dmem_responder #(.WAIT_STATES(2), .DEPTH_WORDS(256), .AW(8)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave)
    );
    dmem_responder #(.WAIT_STATES(0), .DEPTH_WORDS(256), .AW(8)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave)
    );

    logic [31:0] w_rdata;
    logic        w_rvalid, w_stall, w_err;
    assign w_rdata  = sel ? bus1.rdata     : bus0.rdata;
    assign w_rvalid = sel ? bus1.rvalid    : bus0.rvalid;
    assign w_stall  = sel ? bus1.mem_stall : bus0.mem_stall;
    assign w_err    = sel ? bus1.mem_err   : bus0.mem_err;

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running want done");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    // One complete access: drive after a rising edge, hold the request until
    // the edge that ends the response cycle, check stall count and latency.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3,
                          output logic [31:0] rdo, output logic erro);
        int stalls;
        int lat;
        int ws;
        logic got;
        ws     = sel ? 0 : 2;
        stalls = 0;
        lat    = -1;
        got    = 1'b0;
        rdo    = 32'd0;
        erro   = 1'b0;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; addr = a; wdata = wd; funct3 = f3;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (w_stall) stalls++;
            if (w_rvalid) begin
                got  = 1'b1;
                lat  = i;
                rdo  = w_rdata;
                erro = w_err;
            end
        end
        chk({tag, "_timeout"}, 32'(got), 32'd1);
        chk({tag, "_stalls"}, 32'(stalls), 32'(ws + 1));
        chk({tag, "_latency"}, 32'(lat), 32'(ws + 1));
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic st(input string tag, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] f3);
        logic [31:0] r;
        logic e;
        access(tag, 1'b0, 1'b1, a, wd, f3, r, e);
        chk({tag, "_err"}, 32'(e), 32'd0);
    endtask

    task automatic ld(input string tag, input logic [31:0] a, input logic [2:0] f3,
                      input logic [31:0] exp);
        logic [31:0] r;
        logic e;
        access(tag, 1'b1, 1'b0, a, 32'd0, f3, r, e);
        chk({tag, "_err"}, 32'(e), 32'd0);
        chk({tag, "_data"}, r, exp);
    endtask

    task automatic bad(input string tag, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] r;
        logic e;
        access(tag, rd, wr, a, 32'hBADBAD00, f3, r, e);
        chk({tag, "_err"}, 32'(e), 32'd1);
        chk({tag, "_data"}, r, 32'd0);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_rvalid", 32'(bus0.rvalid), 32'd0);
        chk("rst_rdata", bus0.rdata, 32'd0);
        chk("rst_err", 32'(bus0.mem_err), 32'd0);
        chk("rst_stall", 32'(bus0.mem_stall), 32'd0);
        reset = 1'b0;

        // 1) word store then load, WAIT_STATES=2.
        st("sw10", 32'h10, 32'hDEADBEEF, 3'b010);
        ld("lw10", 32'h10, 3'b010, 32'hDEADBEEF);
        @(negedge clk);
        chk("post_rvalid", 32'(w_rvalid), 32'd0);
        chk("post_hold", w_rdata, 32'hDEADBEEF);

        // 2) byte store, signed/unsigned byte loads, neighbours untouched.
        st("sb13", 32'h13, 32'h00000080, 3'b000);
        ld("lb13", 32'h13, 3'b000, 32'hFFFFFF80);
        ld("lbu13", 32'h13, 3'b100, 32'h00000080);
        ld("lw10b", 32'h10, 3'b010, 32'h80ADBEEF);

        // 3) half store, signed/unsigned half loads.
        st("sh22", 32'h22, 32'h00008001, 3'b001);
        ld("lh22", 32'h22, 3'b001, 32'hFFFF8001);
        ld("lhu22", 32'h22, 3'b101, 32'h00008001);

        // 4) error cases; out-of-range store must not alias onto word 0.
        st("sw00", 32'h00, 32'h11112222, 3'b010);
        bad("lw11", 1'b1, 1'b0, 32'h11, 3'b010);
        bad("sw400", 1'b0, 1'b1, 32'h400, 3'b010);
        ld("lw00", 32'h00, 3'b010, 32'h11112222);
        bad("rdwr", 1'b1, 1'b1, 32'h10, 3'b010);
        bad("lh23", 1'b1, 1'b0, 32'h23, 3'b001);
        bad("f3_011", 1'b1, 1'b0, 32'h10, 3'b011);
        ld("lw10c", 32'h10, 3'b010, 32'h80ADBEEF);

        // 5) reset in the middle of a store's wait period.
        st("sw30", 32'h30, 32'hCAFEF00D, 3'b010);
        ld("lw30", 32'h30, 3'b010, 32'hCAFEF00D);
        @(posedge clk); #1;
        mem_write = 1'b1; addr = 32'h30; wdata = 32'h12345678; funct3 = 3'b010;
        @(negedge clk);
        chk("abort_stall_idle", 32'(w_stall), 32'd1);
        @(negedge clk);
        chk("abort_stall_wait", 32'(w_stall), 32'd1);
        #1 reset = 1'b1;
        #1 mem_write = 1'b0;
        chk("abort_rvalid", 32'(w_rvalid), 32'd0);
        chk("abort_rdata", w_rdata, 32'd0);
        chk("abort_err", 32'(w_err), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_no_resp", 32'(w_rvalid), 32'd0);
        ld("lw30b", 32'h30, 3'b010, 32'hCAFEF00D);

        // 6) zero wait states.
        sel = 1'b1;
        st("ws0_sw40", 32'h40, 32'h00000005, 3'b010);
        ld("ws0_lw40", 32'h40, 3'b010, 32'h00000005);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
